// File: rtl/cond_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cond_pkg : condition codes and flag/FlagW bit indices  (rev 1.0)   |
// +--------------------------------------------------------------------+
package cond_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage
`default_nettype wire

// File: rtl/cond_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cond_unit_if : E-stage control bundle between pipeline and         |
// | cond_unit; counters exist only with COND_PERF_EN       (rev 1.0)   |
// +--------------------------------------------------------------------+
interface cond_unit_if
`ifdef COND_PERF_EN
   #(parameter int CNT_W = 32)
`endif
   ;
   logic       ValidE;
   logic       StallE;
   logic       FlushE;
   logic [3:0] CondE;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic       NoWrite;
   logic       MemtoRegE;

   logic       PCSrcE;
   logic       CondExE;
   logic [3:0] Flags;
   logic       RegWriteM;
   logic       MemWriteM;
   logic       MemtoRegM;
`ifdef COND_PERF_EN
   logic [CNT_W-1:0] ExecCnt;
   logic [CNT_W-1:0] SkipCnt;
`endif

   modport master (
      output ValidE, StallE, FlushE, CondE, ALUFlags, FlagW,
             PCS, RegW, MemW, NoWrite, MemtoRegE,
      input  PCSrcE, CondExE, Flags, RegWriteM, MemWriteM, MemtoRegM
`ifdef COND_PERF_EN
      , input ExecCnt, SkipCnt
`endif
   );

   modport slave (
      input  ValidE, StallE, FlushE, CondE, ALUFlags, FlagW,
             PCS, RegW, MemW, NoWrite, MemtoRegE,
      output PCSrcE, CondExE, Flags, RegWriteM, MemWriteM, MemtoRegM
`ifdef COND_PERF_EN
      , output ExecCnt, SkipCnt
`endif
   );

endinterface
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cond_check : combinational ARM condition-field evaluator (rev 1.0) |
// +--------------------------------------------------------------------+
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       pass
);

   logic w_n, w_z, w_c, w_v, w_ge;

   assign w_n  = Flags[FLAG_N];
   assign w_z  = Flags[FLAG_Z];
   assign w_c  = Flags[FLAG_C];
   assign w_v  = Flags[FLAG_V];
   assign w_ge = (w_n == w_v);

   always_comb begin
      pass = 1'b0;
      case (Cond)
         COND_EQ: pass = w_z;
         COND_NE: pass = ~w_z;
         COND_CS: pass = w_c;
         COND_CC: pass = ~w_c;
         COND_MI: pass = w_n;
         COND_PL: pass = ~w_n;
         COND_VS: pass = w_v;
         COND_VC: pass = ~w_v;
         COND_HI: pass = w_c & ~w_z;
         COND_LS: pass = ~w_c | w_z;
         COND_GE: pass = w_ge;
         COND_LT: pass = ~w_ge;
         COND_GT: pass = ~w_z & w_ge;
         COND_LE: pass = w_z | ~w_ge;
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cond_unit : E-stage NZCV register, condition gating and E->M regs. |
// | Optional pass/skip counters under COND_PERF_EN.         (rev 1.0)  |
// +--------------------------------------------------------------------+
module cond_unit
   import cond_pkg::*;
#(
   parameter logic [3:0] FLAG_RST = 4'b0000
`ifdef COND_PERF_EN
   , parameter int CNT_W = 32
`endif
)
(
   input  logic        CLK,
   input  logic        Reset_n,
   cond_unit_if.slave  bus
);

   logic [3:0] flags_q, flags_d;
   logic       regwm_q, memwm_q, mtrm_q;
   logic       w_pass, w_live, w_cond_ex, w_flag_we, w_reg_wr, w_mem_wr;

   // Evaluated against the registered flags, so a CMP feeding the next
   // instruction's condition needs no bypass from ALUFlags.
   cond_check u_cond_check (
      .Cond  (bus.CondE),
      .Flags (flags_q),
      .pass  (w_pass)
   );

   assign w_live    = bus.ValidE & ~bus.FlushE;
   assign w_cond_ex = w_live & w_pass;
   assign w_flag_we = w_cond_ex & ~bus.StallE;
   assign w_reg_wr  = w_cond_ex & bus.RegW & ~bus.NoWrite;
   assign w_mem_wr  = w_cond_ex & bus.MemW;

   assign bus.CondExE   = w_cond_ex;
   assign bus.PCSrcE    = w_cond_ex & bus.PCS;
   assign bus.Flags     = flags_q;
   assign bus.RegWriteM = regwm_q;
   assign bus.MemWriteM = memwm_q;
   assign bus.MemtoRegM = mtrm_q;

   always_comb begin
      flags_d = flags_q;
      if (w_flag_we) begin
         if (bus.FlagW[FLAGW_NZ]) begin
            flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
         end
         if (bus.FlagW[FLAGW_CV]) begin
            flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
            flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
         end
      end
   end

   // Stall outranks flush: a stalled, flushed instruction stays in E.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         flags_q <= FLAG_RST;
         regwm_q <= 1'b0;
         memwm_q <= 1'b0;
         mtrm_q  <= 1'b0;
      end else if (!bus.StallE) begin
         flags_q <= flags_d;
         if (bus.FlushE) begin
            regwm_q <= 1'b0;
            memwm_q <= 1'b0;
            mtrm_q  <= 1'b0;
         end else begin
            regwm_q <= w_reg_wr;
            memwm_q <= w_mem_wr;
            mtrm_q  <= bus.MemtoRegE;
         end
      end
   end

`ifdef COND_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] exec_cnt_q, skip_cnt_q;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         exec_cnt_q <= '0;
         skip_cnt_q <= '0;
      end else if (w_live && !bus.StallE) begin
         if (w_pass) exec_cnt_q <= exec_cnt_q + CNT_ONE;
         else        skip_cnt_q <= skip_cnt_q + CNT_ONE;
      end
   end

   assign bus.ExecCnt = exec_cnt_q;
   assign bus.SkipCnt = skip_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cond_unit : randomized + directed bench for cond_unit (rev 1.0) |
// +--------------------------------------------------------------------+
module tb_cond_unit;

`ifdef COND_PERF_EN
   localparam int TB_CNT_W = 4;
`endif

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   // reference state
   logic [3:0] m_flags;
   logic       m_regw, m_memw, m_mtr;
   int         m_exec, m_skip;

`ifdef COND_PERF_EN
   cond_unit_if #(.CNT_W(TB_CNT_W)) u_if ();
   cond_unit #(.FLAG_RST(4'b0000), .CNT_W(TB_CNT_W)) dut (
      .CLK(clk), .Reset_n(rst_n), .bus(u_if)
   );
`else
   cond_unit_if u_if ();
   cond_unit #(.FLAG_RST(4'b0000)) dut (
      .CLK(clk), .Reset_n(rst_n), .bus(u_if)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural meaning: cond[3:1] picks a predicate, cond[0] inverts it,
   // 1111 never executes.
   function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, b;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cy;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cy && !z;
         3'd5: b = (n == v);
         3'd6: b = !z && (n == v);
         default: b = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return b ^ c[0];
   endfunction

   task automatic model_reset();
      m_flags = 4'b0000;
      m_regw = 0; m_memw = 0; m_mtr = 0;
      m_exec = 0; m_skip = 0;
   endtask

   task automatic drive(input logic v, input logic st, input logic fl,
                        input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs, input logic rw,
                        input logic mw, input logic nw, input logic mtr);
      @(negedge clk);
      u_if.ValidE = v;  u_if.StallE = st; u_if.FlushE = fl;
      u_if.CondE = c;   u_if.ALUFlags = alu; u_if.FlagW = fw;
      u_if.PCS = pcs;   u_if.RegW = rw; u_if.MemW = mw;
      u_if.NoWrite = nw; u_if.MemtoRegE = mtr;
      #1;
   endtask

   // Advance the model with the driven inputs, then let the DUT clock.
   task automatic tick();
      bit ex;
      ex = u_if.ValidE && !u_if.FlushE && ref_pass(u_if.CondE, m_flags);
      if (!u_if.StallE) begin
         if (u_if.ValidE && !u_if.FlushE) begin
            if (ref_pass(u_if.CondE, m_flags)) m_exec++;
            else m_skip++;
         end
         if (ex && u_if.FlagW[1]) m_flags[3:2] = u_if.ALUFlags[3:2];
         if (ex && u_if.FlagW[0]) m_flags[1:0] = u_if.ALUFlags[1:0];
         if (u_if.FlushE) begin
            m_regw = 0; m_memw = 0; m_mtr = 0;
         end else begin
            m_regw = ex && u_if.RegW && !u_if.NoWrite;
            m_memw = ex && u_if.MemW;
            m_mtr  = u_if.MemtoRegE;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (u_if.Flags !== 4'b0000 || u_if.RegWriteM !== 1'b0 || u_if.MemWriteM !== 1'b0
          || u_if.MemtoRegM !== 1'b0) begin
         bad++;
         $display("FAIL reset_init: got flags=%b rw=%b mw=%b mtr=%b want 0000/0/0/0",
                  u_if.Flags, u_if.RegWriteM, u_if.MemWriteM, u_if.MemtoRegM);
      end
      drive(1, 0, 0, 4'hE, 4'hF, 2'b11, 0, 1, 1, 0, 1);
      tick();
      total++;
      if (u_if.Flags !== 4'b1111 || u_if.RegWriteM !== 1'b1 || u_if.MemWriteM !== 1'b1) begin
         bad++;
         $display("FAIL reset_preload: got flags=%b rw=%b mw=%b want 1111/1/1",
                  u_if.Flags, u_if.RegWriteM, u_if.MemWriteM);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (u_if.Flags !== 4'b0000 || u_if.RegWriteM !== 1'b0 || u_if.MemWriteM !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: got flags=%b rw=%b mw=%b want 0000/0/0",
                  u_if.Flags, u_if.RegWriteM, u_if.MemWriteM);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_cmp_beq();
      // CMP sets Z, BEQ taken
      drive(1, 0, 0, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1, 0);
      tick();
      total++;
      if (u_if.Flags !== 4'b0100 || u_if.RegWriteM !== 1'b0) begin
         bad++;
         $display("FAIL cmp_flags: got flags=%b rw=%b want 0100/0", u_if.Flags, u_if.RegWriteM);
      end
      drive(1, 0, 0, 4'h0, 4'b0000, 2'b00, 1, 0, 0, 0, 0);
      total++;
      if (u_if.PCSrcE !== 1'b1) begin
         bad++;
         $display("FAIL beq_taken: got PCSrcE=%b want 1", u_if.PCSrcE);
      end
      tick();
      // CMP clears Z, BEQ not taken and its write suppressed
      drive(1, 0, 0, 4'hE, 4'b0000, 2'b11, 0, 1, 0, 1, 0);
      tick();
      drive(1, 0, 0, 4'h0, 4'b0000, 2'b00, 1, 1, 0, 0, 0);
      total++;
      if (u_if.PCSrcE !== 1'b0) begin
         bad++;
         $display("FAIL beq_not_taken: got PCSrcE=%b want 0", u_if.PCSrcE);
      end
      tick();
      total++;
      if (u_if.RegWriteM !== 1'b0) begin
         bad++;
         $display("FAIL beq_regw: got RegWriteM=%b want 0", u_if.RegWriteM);
      end
   endtask

   task automatic test_partial();
      drive(1, 0, 0, 4'hE, 4'b1010, 2'b11, 0, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 4'hE, 4'b0101, 2'b10, 0, 0, 0, 0, 0);
      tick();
      total++;
      if (u_if.Flags !== 4'b0110) begin
         bad++;
         $display("FAIL partial_nz: got flags=%b want 0110", u_if.Flags);
      end
      drive(1, 0, 0, 4'hE, 4'b1111, 2'b01, 0, 0, 0, 0, 0);
      tick();
      total++;
      if (u_if.Flags !== 4'b0111) begin
         bad++;
         $display("FAIL partial_cv: got flags=%b want 0111", u_if.Flags);
      end
   endtask

   task automatic test_all_codes();
      for (int f = 0; f < 16; f++) begin
         drive(1, 0, 0, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0);
         tick();
         for (int c = 0; c < 16; c++) begin
            drive(1, 0, 0, 4'(c), 4'h0, 2'b00, 1, 0, 0, 0, 0);
            total++;
            if (u_if.CondExE !== ref_pass(4'(c), 4'(f)) || u_if.PCSrcE !== u_if.CondExE) begin
               bad++;
               $display("FAIL cond_table c=%h f=%b: got CondExE=%b PCSrcE=%b want %b",
                        c, f, u_if.CondExE, u_if.PCSrcE, ref_pass(4'(c), 4'(f)));
            end
            u_if.ValidE = 1'b0;
            #1;
            total++;
            if (u_if.CondExE !== 1'b0 || u_if.PCSrcE !== 1'b0) begin
               bad++;
               $display("FAIL cond_bubble c=%h f=%b: got CondExE=%b PCSrcE=%b want 0",
                        c, f, u_if.CondExE, u_if.PCSrcE);
            end
         end
      end
      tick();
   endtask

   task automatic test_stall_flush();
      drive(1, 0, 0, 4'hE, 4'b0011, 2'b11, 0, 1, 1, 0, 1);
      tick();
      drive(1, 1, 0, 4'hE, 4'b1100, 2'b11, 1, 0, 0, 0, 0);
      total++;
      if (u_if.CondExE !== 1'b1) begin
         bad++;
         $display("FAIL stall_condex: got %b want 1", u_if.CondExE);
      end
      tick();
      total++;
      if (u_if.Flags !== 4'b0011 || {u_if.RegWriteM, u_if.MemWriteM, u_if.MemtoRegM} !== 3'b111) begin
         bad++;
         $display("FAIL stall_hold: got flags=%b m=%b want 0011/111",
                  u_if.Flags, {u_if.RegWriteM, u_if.MemWriteM, u_if.MemtoRegM});
      end
      drive(1, 0, 1, 4'hE, 4'b1111, 2'b11, 1, 1, 1, 0, 1);
      total++;
      if (u_if.CondExE !== 1'b0 || u_if.PCSrcE !== 1'b0) begin
         bad++;
         $display("FAIL flush_comb: got CondExE=%b PCSrcE=%b want 0/0", u_if.CondExE, u_if.PCSrcE);
      end
      tick();
      total++;
      if (u_if.Flags !== 4'b0011 || {u_if.RegWriteM, u_if.MemWriteM, u_if.MemtoRegM} !== 3'b000) begin
         bad++;
         $display("FAIL flush_zero: got flags=%b m=%b want 0011/000",
                  u_if.Flags, {u_if.RegWriteM, u_if.MemWriteM, u_if.MemtoRegM});
      end
      drive(1, 0, 0, 4'hE, 4'b0011, 2'b00, 0, 1, 1, 0, 1);
      tick();
      drive(1, 1, 1, 4'hE, 4'b1100, 2'b11, 0, 0, 0, 0, 0);
      tick();
      total++;
      if (u_if.Flags !== 4'b0011 || {u_if.RegWriteM, u_if.MemWriteM, u_if.MemtoRegM} !== 3'b111) begin
         bad++;
         $display("FAIL stall_flush_hold: got flags=%b m=%b want 0011/111",
                  u_if.Flags, {u_if.RegWriteM, u_if.MemWriteM, u_if.MemtoRegM});
      end
   endtask

   task automatic test_random();
      bit exp_ex;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 6) == 0,
               4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), ($urandom % 4) == 0, 1'($urandom));
         exp_ex = u_if.ValidE && !u_if.FlushE && ref_pass(u_if.CondE, m_flags);
         total++;
         if (u_if.CondExE !== exp_ex || u_if.PCSrcE !== (exp_ex && u_if.PCS)) begin
            bad++;
            $display("FAIL rand_comb %0d: got CondExE=%b PCSrcE=%b want %b/%b",
                     i, u_if.CondExE, u_if.PCSrcE, exp_ex, exp_ex && u_if.PCS);
         end
         tick();
         total++;
         if (u_if.Flags !== m_flags || u_if.RegWriteM !== m_regw
             || u_if.MemWriteM !== m_memw || u_if.MemtoRegM !== m_mtr) begin
            bad++;
            $display("FAIL rand_state %0d: got %b/%b%b%b want %b/%b%b%b", i,
                     u_if.Flags, u_if.RegWriteM, u_if.MemWriteM, u_if.MemtoRegM,
                     m_flags, m_regw, m_memw, m_mtr);
         end
`ifdef COND_PERF_EN
         total++;
         if (int'(u_if.ExecCnt) !== (m_exec % (1 << TB_CNT_W))
             || int'(u_if.SkipCnt) !== (m_skip % (1 << TB_CNT_W))) begin
            bad++;
            $display("FAIL rand_cnt %0d: got %0d/%0d want %0d/%0d", i, u_if.ExecCnt,
                     u_if.SkipCnt, m_exec % (1 << TB_CNT_W), m_skip % (1 << TB_CNT_W));
         end
`endif
      end
   endtask

`ifdef COND_PERF_EN
   task automatic test_perf();
      do_reset();
      for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick(); end
      for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick(); end
      for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick(); end
      drive(1, 0, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick();
      total++;
      if (u_if.ExecCnt !== 4'd5 || u_if.SkipCnt !== 4'd3) begin
         bad++;
         $display("FAIL perf_count: got exec=%0d skip=%0d want 5/3", u_if.ExecCnt, u_if.SkipCnt);
      end
      for (int i = 0; i < 10; i++) begin drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick(); end
      total++;
      if (u_if.ExecCnt !== 4'd15) begin
         bad++;
         $display("FAIL perf_max: got exec=%0d want 15", u_if.ExecCnt);
      end
      drive(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0); tick();
      total++;
      if (u_if.ExecCnt !== 4'd0) begin
         bad++;
         $display("FAIL perf_wrap: got exec=%0d want 0", u_if.ExecCnt);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      u_if.ValidE = 0; u_if.StallE = 0; u_if.FlushE = 0; u_if.CondE = 4'h0;
      u_if.ALUFlags = 4'h0; u_if.FlagW = 2'b00; u_if.PCS = 0; u_if.RegW = 0;
      u_if.MemW = 0; u_if.NoWrite = 0; u_if.MemtoRegE = 0;
      model_reset();
      test_reset();
      test_cmp_beq();
      test_partial();
      test_all_codes();
      test_stall_flush();
      do_reset();
      test_random();
`ifdef COND_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
